// File: rtl/fetch_buffer_stage.sv
// fetch_buffer_stage: decoupled instruction fetch over a variable-latency imem with stale-response
// discard on redirect, feeding a DEPTH-entry buffer that presents PC and RISC-V field decode.
module fetch_buffer_stage #(
   parameter int ADDR_LEN = 32,
   parameter int INST_LEN = 32,
   parameter int DEPTH = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
   input  logic clk,
   input  logic reset,
   output logic imem_req_valid,
   input  logic imem_req_ready,
   output logic [ADDR_LEN-1:0] imem_req_addr,
   input  logic imem_resp_valid,
   input  logic [INST_LEN-1:0] imem_resp_data,
   input  logic redirect_valid,
   input  logic [ADDR_LEN-1:0] redirect_pc,
   output logic dec_valid,
   input  logic dec_ready,
   output logic [ADDR_LEN-1:0] dec_pc,
   output logic [INST_LEN-1:0] dec_inst,
   output logic [4:0] dec_rs1,
   output logic [4:0] dec_rs2,
   output logic [4:0] dec_rd,
   output logic [11:0] dec_imm_i,
   output logic [19:0] dec_imm_uj,
   output logic [11:0] dec_imm_bs,
   output logic [6:0] dec_opcode,
   output logic [2:0] dec_func,
   output logic dec_add_rshift_type,
   output logic [$clog2(DEPTH):0] buf_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int NW = (CW > OW ? CW : OW) + 1;

   logic [ADDR_LEN-1:0] fetch_pc, resp_pc;
   logic [OW-1:0] outstanding, drop_cnt, live;
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;
   logic [ADDR_LEN-1:0] fifo_pc [DEPTH];
   logic [INST_LEN-1:0] fifo_inst [DEPTH];
   logic fire, push, pop;

   // only live (non-dropped) requests need a reserved buffer slot
   assign live = outstanding - drop_cnt;
   assign imem_req_valid = !reset && !redirect_valid && (NW'(live) + NW'(count) < NW'(DEPTH))
                           && (outstanding < OW'(MAX_OUTSTANDING));
   assign imem_req_addr = fetch_pc;
   assign fire = imem_req_valid && imem_req_ready;
   assign push = imem_resp_valid && drop_cnt == '0 && !redirect_valid;
   assign dec_valid = !reset && count != '0;
   assign pop = dec_valid && dec_ready && !redirect_valid;
   assign buf_count = count;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc <= RESET_PC;
         outstanding <= '0;
         drop_cnt <= '0;
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         outstanding <= outstanding + OW'(fire) - OW'(imem_resp_valid);
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            resp_pc <= redirect_pc;
            drop_cnt <= outstanding - OW'(imem_resp_valid);
            head <= '0;
            tail <= '0;
            count <= '0;
         end else begin
            if (fire) fetch_pc <= fetch_pc + ADDR_LEN'(4);
            if (imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
            if (push) begin
               tail <= tail + PW'(1);
               resp_pc <= resp_pc + ADDR_LEN'(4);
            end
            if (pop) head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[tail] <= resp_pc;
         fifo_inst[tail] <= imem_resp_data;
      end
   end

   assign dec_pc = fifo_pc[head];
   assign dec_inst = fifo_inst[head];
   assign dec_rs1 = dec_inst[19:15];
   assign dec_rs2 = dec_inst[24:20];
   assign dec_rd = dec_inst[11:7];
   assign dec_imm_i = dec_inst[31:20];
   assign dec_imm_uj = dec_inst[31:12];
   assign dec_imm_bs = {dec_inst[31:25], dec_inst[11:7]};
   assign dec_opcode = dec_inst[6:0];
   assign dec_func = dec_inst[14:12];
   assign dec_add_rshift_type = dec_inst[30];

   assert property (@(posedge clk) disable iff (reset) !(push && count == CW'(DEPTH)));
   assert property (@(posedge clk) disable iff (reset) !(imem_resp_valid && outstanding == '0));
   assert property (@(posedge clk) disable iff (reset) drop_cnt <= outstanding);
endmodule

// File: tb/tb_fetch_buffer_stage.sv
// tb_fetch_buffer_stage: random and directed stimulus against an epoch-tagged imem model;
// expected decode entries are queued on delivery and popped by a separate monitor.
module tb_fetch_buffer_stage;
   localparam int DEPTH = 4;
   localparam int MAX_OUT = 4;

   logic clk, reset;
   logic imem_req_valid, imem_req_ready, imem_resp_valid;
   logic [31:0] imem_req_addr, imem_resp_data;
   logic redirect_valid, dec_valid, dec_ready;
   logic [31:0] redirect_pc, dec_pc, dec_inst;
   logic [4:0] dec_rs1, dec_rs2, dec_rd;
   logic [11:0] dec_imm_i, dec_imm_bs;
   logic [19:0] dec_imm_uj;
   logic [6:0] dec_opcode;
   logic [2:0] dec_func;
   logic dec_add_rshift_type;
   logic [2:0] buf_count;

   fetch_buffer_stage #(.ADDR_LEN(32), .INST_LEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT),
      .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_inst(dec_inst),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_imm_i(dec_imm_i), .dec_imm_uj(dec_imm_uj), .dec_imm_bs(dec_imm_bs),
      .dec_opcode(dec_opcode), .dec_func(dec_func), .dec_add_rshift_type(dec_add_rshift_type),
      .buf_count(buf_count)
   );

   typedef struct {logic [31:0] addr; logic [31:0] data; int epoch; int due;} req_t;
   typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;

   req_t pending[$];
   ent_t exp_q[$];
   int errors = 0, checks = 0;
   int cyc = 0, epoch = 0, last_due = 0, fires = 0;
   logic [31:0] exp_fetch = 32'h0;

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // one cycle: drive inputs, check request/occupancy rules, advance the reference model
   task automatic step(input bit redir, input logic [31:0] rpc, input bit rr, input bit dr,
                       input int lo, input int hi);
      bit resp, fire, exp_rv;
      int live, due;
      req_t p;
      @(negedge clk);
      cyc++;
      resp = pending.size() > 0 && pending[0].due <= cyc;
      redirect_valid = redir;
      redirect_pc = rpc;
      imem_req_ready = rr;
      dec_ready = dr;
      imem_resp_valid = resp;
      imem_resp_data = resp ? pending[0].data : $urandom;
      #1;
      live = 0;
      foreach (pending[i]) if (pending[i].epoch == epoch) live++;
      exp_rv = !redir && (live + exp_q.size() < DEPTH) && pending.size() < MAX_OUT;
      chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (imem_req_valid) chk("req_addr", 64'(imem_req_addr), 64'(exp_fetch));
      chk("buf_count", 64'(buf_count), 64'(exp_q.size()));
      chk("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
      fire = imem_req_valid && rr;
      if (resp) begin
         p = pending.pop_front();
         if (!redir && p.epoch == epoch) exp_q.push_back('{p.addr, p.data});
      end
      if (redir) begin
         exp_q.delete();
         epoch++;
         exp_fetch = rpc;
      end else if (fire) exp_fetch += 32'd4;
      if (fire) begin
         due = cyc + $urandom_range(lo, hi);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pending.push_back('{imem_req_addr, $urandom, epoch, due});
         fires++;
      end
      chk("outstanding_cap", 64'(pending.size() <= MAX_OUT), 64'(1));
   endtask

   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && dec_valid && dec_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_empty: got pc %h expected no entry (cycle %0d)", dec_pc, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("dec_pc", 64'(dec_pc), 64'(e.pc));
               chk("dec_inst", 64'(dec_inst), 64'(e.inst));
               chk("dec_rs1", 64'(dec_rs1), 64'(e.inst[19:15]));
               chk("dec_rs2", 64'(dec_rs2), 64'(e.inst[24:20]));
               chk("dec_rd", 64'(dec_rd), 64'(e.inst[11:7]));
               chk("dec_imm_i", 64'(dec_imm_i), 64'(e.inst[31:20]));
               chk("dec_imm_uj", 64'(dec_imm_uj), 64'(e.inst[31:12]));
               chk("dec_imm_bs", 64'(dec_imm_bs), 64'({e.inst[31:25], e.inst[11:7]}));
               chk("dec_opcode", 64'(dec_opcode), 64'(e.inst[6:0]));
               chk("dec_func", 64'(dec_func), 64'(e.inst[14:12]));
               chk("dec_rshift", 64'(dec_add_rshift_type), 64'(e.inst[30]));
            end
         end
      end
   end

   initial begin
      int f0, n;
      reset = 1;
      imem_req_ready = 1;
      imem_resp_valid = 0;
      imem_resp_data = '0;
      redirect_valid = 0;
      redirect_pc = '0;
      dec_ready = 1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_req_valid", 64'(imem_req_valid), 64'(0));
      chk("reset_dec_valid", 64'(dec_valid), 64'(0));
      reset = 0;
      imem_req_ready = 0;
      repeat (10) step(0, 0, 1, 1, 1, 1);
      step(1, 32'h40, 1, 0, 1, 1);
      f0 = fires;
      repeat (12) step(0, 0, 1, 0, 1, 1);
      chk("fill_fires", 64'(fires - f0), 64'(DEPTH));
      repeat (10) step(0, 0, 1, 1, 1, 1);
      repeat (20) step(0, 0, 1, $urandom_range(0, 1), 3, 3);
      n = 0;
      while (pending.size() < 3 && n < 20) begin
         step(0, 0, 1, 1, 3, 3);
         n++;
      end
      chk("inflight_reached", 64'(pending.size() >= 3), 64'(1));
      step(1, 32'h100, 1, 1, 3, 3);
      repeat (12) step(0, 0, 1, 1, 1, 3);
      n = 0;
      while (!(pending.size() > 0 && pending[0].due <= cyc + 1 && exp_q.size() > 0) && n < 30) begin
         step(0, 0, 1, 0, 2, 2);
         n++;
      end
      chk("coincident_setup", 64'(pending.size() > 0 && exp_q.size() > 0), 64'(1));
      step(1, 32'h200, 1, 1, 2, 2);
      repeat (10) step(0, 0, 1, 1, 1, 2);
      step(1, 32'hFFFF_FFF8, 1, 1, 1, 1);
      repeat (12) step(0, 0, 1, 1, 1, 1);
      repeat (2000) step($urandom_range(0, 29) == 0, $urandom & 32'hFFFF_FFFC,
                         $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1, 4);
      repeat (20) step(0, 0, 0, 1, 1, 1);
      chk("drained", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_buffer_stage.md
Name: fetch_buffer_stage

Overview:
- Parametrised successor to the single-cycle Fetch/Decode stage (stage 1).
- Decouples instruction fetch from decode with a variable-latency, request/response instruction-memory interface and a DEPTH-entry instruction buffer.
- Supports multiple outstanding fetches, redirect with discard of stale in-flight responses, and a ready/valid handoff to decode.
- Presents each buffered instruction with its PC and RISC-V field decode.

Parameters:
ADDR_LEN, 32, PC/address width; increment and wrap are modulo 2^ADDR_LEN
INST_LEN, 32, instruction width; must be >= 32
DEPTH, 4, instruction buffer entries; power of two, >= 2
MAX_OUTSTANDING, 4, cap on issued-but-unanswered imem requests, live plus dropped; >= 1
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  ADDR_LEN  fetch address
imem_resp_valid  in  1  response valid; in order, no backpressure, >= 1 cycle after acceptance
imem_resp_data  in  INST_LEN  fetched instruction
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_LEN  new fetch address
dec_valid  out  1  buffer head valid
dec_ready  in  1  decode consumes head
dec_pc  out  ADDR_LEN  PC of head instruction
dec_inst  out  INST_LEN  head instruction
dec_rs1, dec_rs2, dec_rd  out  5 each  inst[19:15], [24:20], [11:7]
dec_imm_i  out  12  inst[31:20]
dec_imm_uj  out  20  inst[31:12]
dec_imm_bs  out  12  {inst[31:25], inst[11:7]}
dec_opcode  out  7  inst[6:0]
dec_func  out  3  inst[14:12]
dec_add_rshift_type  out  1  inst[30]
buf_count  out  clog2(DEPTH)+1  current buffer occupancy

Behaviour:
State
- fetch_pc: next request address.
- resp_pc: PC of the next non-dropped response.
- outstanding: accepted requests not yet answered.
- drop_cnt: outstanding responses to discard; always <= outstanding.
- Buffer: DEPTH entries of {pc, inst}, plus head/tail pointers and count.

Reset
- fetch_pc = resp_pc = RESET_PC.
- outstanding = drop_cnt = count = 0.
- imem_req_valid = 0 and dec_valid = 0 during the reset cycle.
- Reset mid-operation discards everything. The imem is reset with this block, so no response may arrive for a pre-reset request.

Request issue
- live = outstanding - drop_cnt.
- imem_req_valid = !reset && !redirect_valid && (live + count < DEPTH) && (outstanding < MAX_OUTSTANDING).
- imem_req_addr = fetch_pc.
- On fire (valid && ready): fetch_pc += 4 and outstanding += 1.
- While valid and not ready, addr is held. Valid may drop without a fire only on redirect.
- The credit rule guarantees a free slot for every live response; a push into a full buffer is an assertion failure.

Response
- On resp_valid: outstanding -= 1 (net 0 if a request fires the same cycle).
- If drop_cnt > 0: discard the response and drop_cnt -= 1.
- Otherwise push {resp_pc, resp_data} at tail and resp_pc += 4.
- A pushed entry is visible on dec_* the next cycle. Minimum request-fire to dec_valid latency is 2 cycles.

Decode handoff
- dec_valid = (count != 0).
- All dec_* fields are driven combinationally from the registered head entry.
- Pop on dec_valid && dec_ready.
- Push and pop in the same cycle leave count unchanged.
- When count == 0, dec_* data is don't-care.

Redirect (highest priority after reset)
- In the redirect cycle: no request issues, and the buffer is flushed (count = 0, pointers reset).
- Any same-cycle push or pop is ignored.
- fetch_pc = resp_pc = redirect_pc.
- drop_cnt = outstanding - imem_resp_valid, so the same-cycle response is dropped and all remaining in-flight responses are marked stale.
- dec_valid = 0 the cycle after redirect.
- The first request to redirect_pc issues the following cycle.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.

Arithmetic
- PC increments wrap modulo 2^ADDR_LEN; 0xFFFFFFFC + 4 = 0x0.
- Counters never underflow or overflow; this is checked by assertions.

Test Plan:
- Reset, ready=1, 1-cycle imem, dec_ready=1 -> requests 0x0,0x4,0x8 on consecutive cycles; dec_pc sequence 0x0,0x4,0x8 with dec_valid from cycle 2; buf_count stays <= 1.
- dec_ready=0, imem_req_ready=1, 1-cycle imem -> exactly DEPTH (4) requests fire; req_valid then stays 0; buf_count=4; then dec_ready=1 -> 4 pops in order and fetch resumes.
- MAX_OUTSTANDING=4 with 3-cycle imem latency -> never more than 4 unanswered requests; responses buffered in order with correct PCs.
- 3 requests in flight, redirect_pc=0x100 -> next 3 responses discarded; first dec_pc=0x100; buffer empty the cycle after redirect.
- Redirect coincident with resp_valid and with a dec pop -> response dropped, drop_cnt=outstanding-1, no stale instruction reaches decode.
- Redirect to 0xFFFFFFF8 -> dec_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0; decoded fields match the instruction bit slices.
